turn_signal_input_ctrl: RTL
===========================

// Module: turn_signal_input_ctrl
// PURPOSE
// Upstream front end for the taillight sequencer. Conditions the raw left and right turn switches:
//   - 2-flop synchronization
//   - debouncing
//   - mutual-exclusion locking
// Drives clean, exclusive left/right request levels into the sequencer.
// Also generates the periodic one-cycle step enable (tick) that paces the lamp sequence.
// PARAMETERS
// DIV         4   tick period in clk cycles; legal range >= 2
// DEB_CYCLES  3   consecutive clk cycles a synced input must differ before the debounced value flips; >= 1
// PORTS
// clk       in   1  system clock, all flops rise-edge
// reset     in   1  synchronous, active-high reset
// sw_left   in   1  raw asynchronous left turn switch
// sw_right  in   1  raw asynchronous right turn switch
// left      out  1  exclusive left request to sequencer, registered
// right     out  1  exclusive right request to sequencer, registered
// tick      out  1  one-cycle step enable, registered, period DIV
// BEHAVIOUR
// Interface: one clock (clk); reset is synchronous and active-high.
// Reset: every flop clears on the clock edge where reset=1. This includes:
//   - sync flops, debounced values, debounce counters, divider counter
//   - state, which goes to IDLE
// Output reset values: left=0, right=0, tick=0.
// Reset asserted mid-operation has the same effect; all outputs are 0 after that edge.
// Sync: per channel s1<=sw_x; s2<=s1. s2 is the only consumer-visible copy.
// Debounce, per channel, with counter width $clog2(DEB_CYCLES)+1:
//   - if s2==deb: cnt<=0
//   - else if cnt==DEB_CYCLES-1: deb<=s2, cnt<=0
//   - else: cnt<=cnt+1
// Effect of the debounce rule: any cycle with s2==deb restarts the count, so glitches shorter than DEB_CYCLES are rejected.
// Divider: div_cnt counts 0..DIV-1 and wraps to 0.
//   - tick<=1 on the edge where div_cnt==DIV-1, else tick<=0
//   - result: tick is high exactly 1 of every DIV cycles
//   - first tick is high in the cycle after the DIV-th edge following reset release
// Lock FSM: states IDLE, LEFT, RIGHT. State changes only on edges where tick==1, using deb values in that cycle.
// IDLE transitions:
//   - deb_l & ~deb_r -> LEFT
//   - deb_r & ~deb_l -> RIGHT
//   - both or neither -> IDLE
// Both switches active simultaneously: no request is granted.
// LEFT transitions:
//   - deb_l -> stay LEFT; deb_r is ignored
//   - ~deb_l -> IDLE
// RIGHT: mirror of LEFT.
// LEFT -> RIGHT never occurs directly. The switch always passes through IDLE for at least one tick period.
// Outputs: left=(state==LEFT), right=(state==RIGHT). They are never both 1.
// Latency, raw edge to output: 2 sync cycles + DEB_CYCLES + wait to next tick (0..DIV-1 cycles) + 1 register edge.
// Unused state encodings recover to IDLE on the next edge.
// TESTING
// DIV=4, DEB_CYCLES=3 for all scenarios.
// 1. reset 3 cycles then release, switches 0 -> tick pulses at cycles 4,8,12 after release; left=right=0 throughout.
// 2. sw_left 0->1 held -> deb_l high 5 edges later. left=1 after the next tick edge and stays 1.
//    Then sw_left->0 -> left=0 within 5+4 edges.
// 3. sw_left toggling every cycle for 20 cycles -> deb_l never flips; left stays 0; tick unaffected.
// 4. sw_left & sw_right rise the same cycle -> left=right=0 indefinitely.
//    Then drop sw_right -> left=1 at the first tick after deb_r clears.
// 5. left locked, raise sw_right -> right stays 0.
//    Then drop sw_left -> left=0 at tick N, right=1 at tick N+1; never both 1.
// 6. reset pulsed 1 cycle while in LEFT -> left=0 and tick=0 after that edge; divider restarts, first tick 4 cycles after release.

Source files
------------

// File: rtl/turn_signal_input_ctrl.sv
// Turn signal input conditioning for the taillight sequencer.
// Synchronizes and debounces the raw left/right switches, locks them into
// mutually exclusive request levels, and generates the periodic step tick.
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous active-high reset
//   sw_left   raw asynchronous left turn switch
//   sw_right  raw asynchronous right turn switch
//   left      exclusive left request (registered)
//   right     exclusive right request (registered)
//   tick      one-cycle step enable, period DIV (registered)
module turn_signal_input_ctrl #(
  parameter int unsigned DIV        = 4,
  parameter int unsigned DEB_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_left,
  input  logic sw_right,
  output logic left,
  output logic right,
  output logic tick
);

  localparam int unsigned CW = $clog2(DEB_CYCLES) + 1;
  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam int unsigned CH_L = 0;
  localparam int unsigned CH_R = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  logic [1:0]    s1;
  logic [1:0]    s2;
  logic [1:0]    deb;
  logic [CW-1:0] cnt [2];
  logic [DW-1:0] div_cnt;
  state_t        state;
  state_t        state_next;

  // Two-flop synchronizer and per-channel debounce; any agreeing cycle restarts the count
  always_ff @(posedge clk) begin
    if (reset) begin
      s1     <= '0;
      s2     <= '0;
      deb    <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      s1 <= {sw_right, sw_left};
      s2 <= s1;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_LAST) begin
          deb[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Step divider: tick is high for one cycle out of every DIV
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + DW'(1);
      tick    <= 1'b0;
    end
  end

  // Lock FSM state register; outputs are registered from the next state so they track state exactly
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      left  <= 1'b0;
      right <= 1'b0;
    end else begin
      state <= state_next;
      left  <= (state_next == LEFT);
      right <= (state_next == RIGHT);
    end
  end

  // Lock FSM next state: moves only on tick; a held side ignores the other switch
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (tick) begin
          if (deb[CH_L] && !deb[CH_R]) begin
            state_next = LEFT;
          end else if (deb[CH_R] && !deb[CH_L]) begin
            state_next = RIGHT;
          end
        end
      end
      LEFT: begin
        if (tick && !deb[CH_L]) begin
          state_next = IDLE;
        end
      end
      RIGHT: begin
        if (tick && !deb[CH_R]) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
